// File: rtl/wb_burst_pkg.sv
// Shared definitions for the Wishbone read-burst prefetcher.
//   state_e   : controller states (IDLE, BURST, FLUSH)
//   CTI_*     : Wishbone B3 cycle type identifiers
//   BTE_*     : Wishbone B3 burst type extensions
//   next_adr  : next beat address for a given burst type
package wb_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    // Operates on the low six address bits only, so it is independent of the
    // address width. Bit 6 of the result is the carry out of a linear step;
    // wrapping bursts never produce a carry.
    function automatic logic [6:0] next_adr(input logic [5:0] adr, input logic [1:0] bte);
        logic [6:0] r;
        r = {1'b0, adr};
        case (bte)
            BTE_LINEAR: r      = {1'b0, adr} + 7'd4;
            BTE_WRAP4:  r[3:2] = adr[3:2] + 2'd1;
            BTE_WRAP8:  r[4:2] = adr[4:2] + 3'd1;
            default:    r[5:2] = adr[5:2] + 4'd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_burst_fifo.sv
// Synchronous first-word-fall-through FIFO holding prefetched read data.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : empty the FIFO (takes priority over push)
//   push, din  : write one word (ignored when full)
//   pop        : drop the head word (ignored when empty)
//   dout       : current head word
//   empty, full, count : occupancy
module wb_burst_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    output logic [W-1:0]               dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push & ~full & ~clr;
        do_pop   = pop & ~empty & ~clr;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_burst_prefetch.sv
// Wishbone B3 read-burst prefetcher in front of a classic-only slave.
// Incrementing read bursts are turned into speculative classic single reads
// whose data is buffered and returned to the master one beat per cycle.
// Everything else (writes, classic, constant-address cycles) passes through.
//   wb_clk, wb_rst        : clock, synchronous active-high reset
//   wbm_*_i / wbm_*_o     : master-facing B3 port
//   wbs_*_o / wbs_*_i     : slave-facing classic port
module wb_burst_prefetch
    import wb_burst_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DEPTH = 4
) (
    input  logic          wb_clk,
    input  logic          wb_rst,
    input  logic [AW-1:0] wbm_adr_i,
    input  logic [31:0]   wbm_dat_i,
    input  logic [3:0]    wbm_sel_i,
    input  logic          wbm_we_i,
    input  logic          wbm_cyc_i,
    input  logic          wbm_stb_i,
    input  logic [2:0]    wbm_cti_i,
    input  logic [1:0]    wbm_bte_i,
    output logic [31:0]   wbm_dat_o,
    output logic          wbm_ack_o,
    output logic [AW-1:0] wbs_adr_o,
    output logic [31:0]   wbs_dat_o,
    output logic [3:0]    wbs_sel_o,
    output logic          wbs_we_o,
    output logic          wbs_cyc_o,
    output logic          wbs_stb_o,
    input  logic [31:0]   wbs_dat_i,
    input  logic          wbs_ack_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q, state_d;
    logic [AW-1:0] pf_adr_q, pf_adr_d;
    logic [1:0]    bte_q, bte_d;
    logic          out_q, out_d;        // slave read issued and not yet acked

    logic          fifo_push, fifo_pop, fifo_clr;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_dout;

    logic          issue, slv_done, end_burst;
    logic [6:0]    nxt_lo;

    wb_burst_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (wb_clk),
        .rst   (wb_rst),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .din   (wbs_dat_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        pf_adr_d  = pf_adr_q;
        bte_d     = bte_q;
        out_d     = out_q;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        fifo_clr  = 1'b0;
        issue     = 1'b0;
        slv_done  = 1'b0;
        end_burst = 1'b0;
        nxt_lo    = next_adr(pf_adr_q[5:0], bte_q);
        wbm_dat_o = '0;
        wbm_ack_o = 1'b0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;

        if (!wb_rst) begin
            case (state_q)
                ST_IDLE: begin
                    wbs_adr_o = wbm_adr_i;
                    wbs_dat_o = wbm_dat_i;
                    wbs_sel_o = wbm_sel_i;
                    wbs_we_o  = wbm_we_i;
                    wbs_cyc_o = wbm_cyc_i;
                    wbs_stb_o = wbm_stb_i;
                    wbm_ack_o = wbs_ack_i;
                    wbm_dat_o = wbs_dat_i;
                    if (wbm_cyc_i && wbm_stb_i && !wbm_we_i && wbm_cti_i == CTI_INC) begin
                        // Burst start cycle: nothing goes downstream yet.
                        wbs_cyc_o = 1'b0;
                        wbs_stb_o = 1'b0;
                        wbm_ack_o = 1'b0;
                        pf_adr_d  = wbm_adr_i;
                        bte_d     = wbm_bte_i;
                        out_d     = 1'b0;
                        state_d   = ST_BURST;
                    end
                end

                ST_BURST: begin
                    issue     = out_q | (fifo_count < CW'(DEPTH));
                    slv_done  = issue & wbs_ack_i;
                    wbs_cyc_o = issue;
                    wbs_stb_o = issue;
                    wbs_adr_o = pf_adr_q;
                    wbs_sel_o = 4'hf;
                    wbm_ack_o = wbm_cyc_i & wbm_stb_i & ~fifo_empty;
                    wbm_dat_o = fifo_dout;
                    fifo_pop  = wbm_ack_o;
                    if (slv_done) begin
                        // Upper bits only move on a linear carry out of bit 5.
                        pf_adr_d = {pf_adr_q[AW-1:6] + (AW-6)'(nxt_lo[6]), nxt_lo[5:0]};
                    end
                    end_burst = ~wbm_cyc_i | (wbm_ack_o & (wbm_cti_i == CTI_EOB));
                    if (end_burst) begin
                        fifo_clr = 1'b1;
                        out_d    = 1'b0;
                        state_d  = (issue && !wbs_ack_i) ? ST_FLUSH : ST_IDLE;
                    end else begin
                        fifo_push = slv_done & ~fifo_full;
                        out_d     = issue & ~wbs_ack_i;
                    end
                end

                ST_FLUSH: begin
                    wbs_cyc_o = 1'b1;
                    wbs_stb_o = 1'b1;
                    wbs_adr_o = pf_adr_q;
                    wbs_sel_o = 4'hf;
                    if (wbs_ack_i) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q  <= ST_IDLE;
            pf_adr_q <= '0;
            bte_q    <= BTE_LINEAR;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pf_adr_q <= pf_adr_d;
            bte_q    <= bte_d;
            out_q    <= out_d;
        end
    end

endmodule

// File: tb/tb_wb_burst_prefetch.sv
module tb_wb_burst_prefetch;
    import wb_burst_pkg::*;

    logic        clk;
    logic        wb_rst;
    logic [31:0] wbm_adr_i, wbm_dat_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_we_i, wbm_cyc_i, wbm_stb_i;
    logic [2:0]  wbm_cti_i;
    logic [1:0]  wbm_bte_i;
    logic [31:0] wbm_dat_o;
    logic        wbm_ack_o;
    logic [31:0] wbs_adr_o, wbs_dat_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_we_o, wbs_cyc_o, wbs_stb_o;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_i;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int slv_lat = 1;
    int start_cyc = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          ack_cyc_q[$];
    logic [31:0] slv_adr_q[$];

    localparam logic [31:0] XMASK = 32'hA5A5A5A5;

    wb_burst_prefetch #(.AW(32), .DEPTH(4)) dut (
        .wb_clk    (clk),
        .wb_rst    (wb_rst),
        .wbm_adr_i (wbm_adr_i),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_i (wbm_sel_i),
        .wbm_we_i  (wbm_we_i),
        .wbm_cyc_i (wbm_cyc_i),
        .wbm_stb_i (wbm_stb_i),
        .wbm_cti_i (wbm_cti_i),
        .wbm_bte_i (wbm_bte_i),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_o (wbm_ack_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_we_o  (wbs_we_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_i (wbs_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc_n++;
        end
    end

    // Slave model: acks a held request slv_lat cycles after it first appears,
    // returning address ^ XMASK; logs every completed read address.
    initial begin
        int cnt;
        logic nxt;
        logic [31:0] nadr;
        wbs_ack_i = 1'b0;
        wbs_dat_i = '0;
        cnt = 0;
        nadr = '0;
        forever begin
            @(negedge clk);
            nxt = 1'b0;
            if (wbs_cyc_o && wbs_stb_o && wbs_ack_i) begin
                if (!wbs_we_o) slv_adr_q.push_back(wbs_adr_o);
                cnt = 0;
            end else if (wbs_cyc_o && wbs_stb_o && !wb_rst) begin
                cnt++;
                if (cnt >= slv_lat) begin
                    nxt  = 1'b1;
                    nadr = wbs_adr_o;
                end
            end else begin
                cnt = 0;
            end
            @(posedge clk);
            #1;
            wbs_ack_i = nxt;
            wbs_dat_i = nxt ? (nadr ^ XMASK) : 32'h0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_master();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
        wbm_cti_i = CTI_CLASSIC;
        wbm_bte_i = BTE_LINEAR;
        wbm_adr_i = '0;
        wbm_dat_i = '0;
        wbm_sel_i = '0;
    endtask

    task automatic start_burst(input logic [31:0] adr, input logic [1:0] bte);
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = 1'b0;
        wbm_cti_i = CTI_INC;
        wbm_bte_i = bte;
        wbm_adr_i = adr;
        wbm_sel_i = 4'hf;
        start_cyc = cyc_n;
    endtask

    // Collects n master acks (data and cycle offset from burst start).
    task automatic master_beats(input int n, input bit eob_last, output bit to);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 100) begin
            @(negedge clk);
            if (wbm_ack_o) begin
                got_q.push_back(wbm_dat_o);
                ack_cyc_q.push_back(cyc_n - start_cyc);
                k++;
            end
            step();
            guard++;
            wbm_cti_i = (eob_last && k == n - 1) ? CTI_EOB : CTI_INC;
        end
        to = (k < n);
    endtask

    // Waits until the slave port goes idle; reports any master ack seen meanwhile.
    task automatic drain_bus(output bit to, output bit spurious);
        bit done = 0;
        spurious = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (wbm_ack_o) spurious = 1;
            if (!wbs_cyc_o) done = 1;
            step();
        end
        to = !done;
    endtask

    task automatic clear_logs();
        exp_q.delete();
        got_q.delete();
        ack_cyc_q.delete();
        slv_adr_q.delete();
    endtask

    task automatic test_reset();
        wb_rst    = 1'b1;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = 1'b1;
        wbm_cti_i = CTI_CLASSIC;
        wbm_bte_i = BTE_LINEAR;
        wbm_adr_i = 32'h1234_5678;
        wbm_dat_i = 32'h55AA_55AA;
        wbm_sel_i = 4'hf;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({wbs_cyc_o, wbs_stb_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_slave_req: got cyc/stb %b%b want 00", wbs_cyc_o, wbs_stb_o);
        end
        checks++;
        if (wbm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_master_ack: got %b want 0", wbm_ack_o);
        end
        checks++;
        if (wbs_adr_o !== 32'h0 || wbs_dat_o !== 32'h0 || wbs_sel_o !== 4'h0 || wbs_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_slave_zero: got adr %h dat %h sel %h we %b want all 0",
                     wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o);
        end
        checks++;
        if (wbm_dat_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_master_dat: got %h want 0", wbm_dat_o);
        end
        step();
        wb_rst = 1'b0;
        idle_master();
        step();
    endtask

    task automatic test_classic_write();
        bit got_ack = 0;
        int ack_at = -1;
        slv_lat = 2;
        step();
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = 1'b1;
        wbm_cti_i = CTI_CLASSIC;
        wbm_adr_i = 32'h100;
        wbm_dat_i = 32'hDEADBEEF;
        wbm_sel_i = 4'hf;
        for (int i = 0; i < 10 && !got_ack; i++) begin
            @(negedge clk);
            checks++;
            if ({wbs_cyc_o, wbs_stb_o, wbs_we_o} !== 3'b111 || wbs_adr_o !== 32'h100 ||
                wbs_dat_o !== 32'hDEADBEEF || wbs_sel_o !== 4'hf) begin
                errors++;
                $display("FAIL wr_mirror: got cyc/stb/we %b%b%b adr %h dat %h sel %h want 111 100 deadbeef f",
                         wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o, wbs_sel_o);
            end
            checks++;
            if (wbm_ack_o !== wbs_ack_i) begin
                errors++;
                $display("FAIL wr_ack_same_cycle: got %b want %b", wbm_ack_o, wbs_ack_i);
            end
            if (wbs_ack_i) begin
                got_ack = 1;
                ack_at  = i;
            end else begin
                step();
            end
        end
        checks++;
        if (ack_at !== 2) begin
            errors++;
            $display("FAIL wr_ack_latency: got cycle %0d want 2", ack_at);
        end
        step();
        idle_master();
        @(negedge clk);
        checks++;
        if (wbs_cyc_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_release: got cyc %b ack %b want 0 0", wbs_cyc_o, wbm_ack_o);
        end
        step();
    endtask

    task automatic test_linear_burst();
        bit to, dto, spur;
        int n;
        clear_logs();
        slv_lat = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back((32'h1000 + 32'(4 * i)) ^ XMASK);
        step();
        start_burst(32'h1000, BTE_LINEAR);
        master_beats(4, 1'b1, to);
        idle_master();
        drain_bus(dto, spur);
        checks++;
        if (to || dto) begin
            errors++;
            $display("FAIL lin_timeout: got beat timeout %b drain timeout %b want 0 0", to, dto);
        end
        checks++;
        if (spur) begin
            errors++;
            $display("FAIL lin_spurious_ack: got master ack after EOB want none");
        end
        n = got_q.size();
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL lin_data[%0d]: got %h want %h", i, got_q[i], e);
            end
        end
        checks++;
        if (ack_cyc_q.size() < 1 || ack_cyc_q[0] != 3) begin
            errors++;
            $display("FAIL lin_first_latency: got %0d want 3", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1);
        end
        checks++;
        if (slv_adr_q.size() < 4 || slv_adr_q.size() > 8) begin
            errors++;
            $display("FAIL lin_slave_count: got %0d want 4..8", slv_adr_q.size());
        end
        for (int i = 0; i < slv_adr_q.size(); i++) begin
            checks++;
            if (slv_adr_q[i] !== 32'h1000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL lin_slave_adr[%0d]: got %h want %h", i, slv_adr_q[i], 32'h1000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap4();
        bit to, dto, spur;
        int n;
        clear_logs();
        slv_lat = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back((32'h2000 | 32'(((2 + i) % 4) * 4)) ^ XMASK);
        step();
        start_burst(32'h2008, BTE_WRAP4);
        master_beats(4, 1'b1, to);
        idle_master();
        drain_bus(dto, spur);
        checks++;
        if (to || dto || spur) begin
            errors++;
            $display("FAIL wrap_flow: got timeout %b drain %b spurious %b want 0 0 0", to, dto, spur);
        end
        n = got_q.size();
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %h want %h", i, got_q[i], e);
            end
        end
        checks++;
        if (slv_adr_q.size() < 4 || slv_adr_q.size() > 8) begin
            errors++;
            $display("FAIL wrap_slave_count: got %0d want 4..8", slv_adr_q.size());
        end
        for (int i = 0; i < slv_adr_q.size(); i++) begin
            logic [31:0] ea;
            ea = 32'h2000 | 32'(((2 + i) % 4) * 4);
            checks++;
            if (slv_adr_q[i] !== ea) begin
                errors++;
                $display("FAIL wrap_slave_adr[%0d]: got %h want %h", i, slv_adr_q[i], ea);
            end
        end
    endtask

    task automatic test_stall();
        bit to1, to2, dto, spur;
        bit stall_ack = 0;
        int n;
        clear_logs();
        slv_lat = 1;
        for (int i = 0; i < 5; i++) exp_q.push_back((32'h4000 + 32'(4 * i)) ^ XMASK);
        step();
        start_burst(32'h4000, BTE_LINEAR);
        master_beats(1, 1'b0, to1);
        wbm_stb_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (wbm_ack_o) stall_ack = 1;
            step();
        end
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 1'b0 || slv_adr_q.size() != 5) begin
            errors++;
            $display("FAIL stall_fill: got stb %b slave reads %0d want 0 5", wbs_stb_o, slv_adr_q.size());
        end
        checks++;
        if (stall_ack) begin
            errors++;
            $display("FAIL stall_no_ack: got master ack while stb low want none");
        end
        step();
        wbm_stb_i = 1'b1;
        master_beats(4, 1'b1, to2);
        idle_master();
        drain_bus(dto, spur);
        checks++;
        if (to1 || to2 || dto || spur) begin
            errors++;
            $display("FAIL stall_flow: got timeouts %b%b%b spurious %b want 000 0", to1, to2, dto, spur);
        end
        n = got_q.size();
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h want %h", i, got_q[i], e);
            end
        end
        for (int i = 2; i < ack_cyc_q.size(); i++) begin
            checks++;
            if (ack_cyc_q[i] != ack_cyc_q[i-1] + 1) begin
                errors++;
                $display("FAIL stall_b2b[%0d]: got cycle %0d want %0d", i, ack_cyc_q[i], ack_cyc_q[i-1] + 1);
            end
        end
    endtask

    task automatic test_drop_cyc();
        bit seen = 0;
        int ack_c = -1;
        bit rd_done = 0;
        clear_logs();
        slv_lat = 5;
        step();
        start_burst(32'h5000, BTE_LINEAR);
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_start_quiet: got stb %b ack %b want 0 0", wbs_stb_o, wbm_ack_o);
        end
        step();
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 1'b1 || wbs_adr_o !== 32'h5000) begin
            errors++;
            $display("FAIL drop_issue: got stb %b adr %h want 1 5000", wbs_stb_o, wbs_adr_o);
        end
        step();
        idle_master();
        for (int c = 2; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (wbs_ack_i) begin
                seen  = 1;
                ack_c = c;
                checks++;
                if (wbm_ack_o !== 1'b0 || wbs_stb_o !== 1'b1) begin
                    errors++;
                    $display("FAIL drop_flush_ack: got master ack %b stb %b want 0 1", wbm_ack_o, wbs_stb_o);
                end
            end else begin
                checks++;
                if (wbs_stb_o !== 1'b1 || wbs_adr_o !== 32'h5000 || wbm_ack_o !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_flush_hold: got stb %b adr %h ack %b want 1 5000 0",
                             wbs_stb_o, wbs_adr_o, wbm_ack_o);
                end
                step();
            end
        end
        checks++;
        if (ack_c != 6) begin
            errors++;
            $display("FAIL drop_flush_len: got ack cycle %0d want 6", ack_c);
        end
        step();
        @(negedge clk);
        checks++;
        if (wbs_stb_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL drop_flush_done: got stb %b ack %b want 0 0", wbs_stb_o, wbm_ack_o);
        end
        slv_lat = 2;
        exp_q.push_back(32'h3000 ^ XMASK);
        step();
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
        wbm_we_i  = 1'b0;
        wbm_cti_i = CTI_CLASSIC;
        wbm_adr_i = 32'h3000;
        wbm_sel_i = 4'hf;
        for (int i = 0; i < 10 && !rd_done; i++) begin
            @(negedge clk);
            checks++;
            if (wbm_ack_o !== wbs_ack_i) begin
                errors++;
                $display("FAIL rd3000_ack_pass: got %b want %b", wbm_ack_o, wbs_ack_i);
            end
            if (wbm_ack_o) begin
                logic [31:0] e;
                rd_done = 1;
                e = exp_q.pop_front();
                checks++;
                if (wbm_dat_o !== e) begin
                    errors++;
                    $display("FAIL rd3000_data: got %h want %h", wbm_dat_o, e);
                end
            end else begin
                step();
            end
        end
        checks++;
        if (!rd_done) begin
            errors++;
            $display("FAIL rd3000_timeout: got no ack want ack");
        end
        step();
        idle_master();
        step();
    endtask

    task automatic test_reset_mid();
        bit filled = 0;
        bit to, dto, spur;
        int n;
        clear_logs();
        slv_lat = 1;
        step();
        start_burst(32'h6000, BTE_LINEAR);
        step();
        wbm_stb_i = 1'b0;
        for (int i = 0; i < 20 && !filled; i++) begin
            @(negedge clk);
            #1;
            if (slv_adr_q.size() >= 2) filled = 1;
            else step();
        end
        step();
        wb_rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            checks++;
            if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || wbm_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet[%0d]: got cyc %b stb %b ack %b want 0 0 0",
                         r, wbs_cyc_o, wbs_stb_o, wbm_ack_o);
            end
            step();
        end
        wb_rst = 1'b0;
        idle_master();
        step();
        clear_logs();
        exp_q.push_back(32'h7000 ^ XMASK);
        exp_q.push_back(32'h7004 ^ XMASK);
        step();
        start_burst(32'h7000, BTE_LINEAR);
        master_beats(2, 1'b1, to);
        idle_master();
        drain_bus(dto, spur);
        checks++;
        if (!filled || to || dto || spur) begin
            errors++;
            $display("FAIL rstmid_flow: got filled %b timeout %b drain %b spurious %b want 1 0 0 0",
                     filled, to, dto, spur);
        end
        n = got_q.size();
        for (int i = 0; i < n; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q[i] !== e) begin
                errors++;
                $display("FAIL rstmid_data[%0d]: got %h want %h", i, got_q[i], e);
            end
        end
        checks++;
        if (ack_cyc_q.size() < 1 || ack_cyc_q[0] != 3) begin
            errors++;
            $display("FAIL rstmid_first_latency: got %0d want 3", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1);
        end
        checks++;
        if (slv_adr_q.size() < 1 || slv_adr_q[0] !== 32'h7000) begin
            errors++;
            $display("FAIL rstmid_slave_adr: got %h want 7000", (slv_adr_q.size() > 0) ? slv_adr_q[0] : 32'hx);
        end
    endtask

    initial begin
        idle_master();
        wb_rst = 1'b1;
        test_reset();
        test_classic_write();
        test_linear_burst();
        test_wrap4();
        test_stall();
        test_drop_cyc();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
